// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a byte-wide RAM port between instruction fetch and the MEM stage,
// serialising little-endian accesses and extending loads.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter bit MEM_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  mem_req,
    input  logic                  mem_wr,
    input  logic [1:0]            mem_cnf,
    input  logic                  mem_signed,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);
    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_n;
    logic [2:0]            r_cyc;
    logic [1:0]            r_cnf;
    logic                  r_signed;
    logic [31:0]           r_wdata;
    logic [31:0]           r_buf;
    logic                  w_if_v;
    logic                  w_mem_v;
    logic                  w_pick_mem;
    logic [2:0]            w_mem_n;
    logic [2:0]            w_next;
    logic                  w_more;
    logic [ADDR_WIDTH-1:0] w_next_a;
    logic [7:0]            w_next_byte;
    logic [4:0]            w_shift;
    logic [31:0]           w_full;
    logic [31:0]           w_ext;
    always_comb begin
        w_if_v      = if_req & ~if_flush;
        w_mem_v     = mem_req & (mem_cnf != 2'd0);
        w_pick_mem  = w_mem_v & (MEM_FIRST | ~w_if_v);
        w_mem_n     = mem_cnf == 2'd1 ? 3'd1 : mem_cnf == 2'd2 ? 3'd2 : 3'd4;
        w_next      = r_cyc + 3'd1;
        w_more      = w_next < r_n;
        w_next_a    = r_addr + ADDR_WIDTH'(w_next);
        w_next_byte = 8'(r_wdata >> {w_next[1:0], 3'b000});
        // ram_din in cycle c carries the byte addressed in cycle c-1
        w_shift     = {r_cyc[1:0] - 2'd1, 3'b000};
        w_full      = r_buf | (32'(ram_din) << w_shift);
        w_ext       = r_cnf == 2'd1 ? {{24{r_signed & w_full[7]}}, w_full[7:0]} :
                      r_cnf == 2'd2 ? {{16{r_signed & w_full[15]}}, w_full[15:0]} : w_full;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_n       <= '0;
            r_cyc     <= '0;
            r_cnf     <= '0;
            r_signed  <= 1'b0;
            r_wdata   <= '0;
            r_buf     <= '0;
            if_done   <= 1'b0;
            if_data   <= '0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (r_state)
                IDLE: if (w_mem_v || w_if_v) begin
                    r_addr   <= w_pick_mem ? mem_addr : if_addr;
                    ram_a    <= w_pick_mem ? mem_addr : if_addr;
                    r_n      <= w_pick_mem ? w_mem_n : 3'd4;
                    r_cnf    <= w_pick_mem ? mem_cnf : 2'd3;
                    r_signed <= mem_signed;
                    r_wdata  <= mem_wdata;
                    r_cyc    <= '0;
                    r_buf    <= '0;
                    ram_wr   <= w_pick_mem & mem_wr;
                    ram_dout <= (w_pick_mem & mem_wr) ? mem_wdata[7:0] : 8'd0;
                    r_state  <= !w_pick_mem ? IF_RD : mem_wr ? MEM_WR : MEM_RD;
                end
                IF_RD, MEM_RD: if (r_state == IF_RD && if_flush) begin
                    r_state <= IDLE;
                    ram_a   <= '0;
                end else begin
                    r_cyc <= w_next;
                    ram_a <= w_more ? w_next_a : '0;
                    if (r_cyc != 3'd0) r_buf <= w_full;
                    if (r_cyc == r_n) begin
                        r_state <= DONE;
                        if (r_state == IF_RD) begin
                            if_done <= 1'b1;
                            if_data <= w_full;
                        end else begin
                            mem_done  <= 1'b1;
                            mem_rdata <= w_ext;
                        end
                    end
                end
                MEM_WR: begin
                    r_cyc    <= w_next;
                    ram_a    <= w_more ? w_next_a : '0;
                    ram_wr   <= w_more;
                    ram_dout <= w_more ? w_next_byte : 8'd0;
                    if (!w_more) begin
                        mem_done <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for mem_arbiter.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0, if_done;
    logic [31:0] if_addr = '0, if_data;
    logic        mem_req = 1'b0, mem_wr = 1'b0, mem_signed = 1'b0, mem_done;
    logic [1:0]  mem_cnf = '0;
    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout, ram_din;
    logic [7:0]  ram [0:65535];
    logic        ld_en = 1'b0;
    logic [15:0] ld_a = '0;
    logic [7:0]  ld_d = '0;
    int total = 0, bad = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  cnf;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
    } vec_t;
    vec_t v [12];

    mem_arbiter #(.ADDR_WIDTH(32), .MEM_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_cnf(mem_cnf), .mem_signed(mem_signed),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) ram[ld_a] <= ld_d;
        else if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
        ram_din <= ram[ram_a[15:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_a = a; ld_d = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic set_mem(input logic wr, input logic [1:0] cnf, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
        mem_wr = wr; mem_cnf = cnf; mem_signed = sg; mem_addr = a; mem_wdata = wd; mem_req = 1'b1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " outs"}, {ram_a, ram_dout, ram_wr, if_done, mem_done}, '0);
        chk({nm, " data"}, {if_data, mem_rdata}, '0);
    endtask

    initial begin
        int got, gif, gmem;
        logic [31:0] rd;
        v[0]  = '{1'b0, 2'd1, 1'b1, 32'h2000, 32'h0, 32'hFFFFFF80, 3};
        v[1]  = '{1'b0, 2'd1, 1'b0, 32'h2000, 32'h0, 32'h00000080, 3};
        v[2]  = '{1'b0, 2'd2, 1'b1, 32'h2010, 32'h0, 32'hFFFF9234, 4};
        v[3]  = '{1'b0, 2'd2, 1'b0, 32'h2010, 32'h0, 32'h00009234, 4};
        v[4]  = '{1'b0, 2'd3, 1'b1, 32'h2020, 32'h0, 32'hF2345678, 6};
        v[5]  = '{1'b1, 2'd3, 1'b0, 32'h2030, 32'hCAFEBABE, 32'h0, 5};
        v[6]  = '{1'b0, 2'd3, 1'b0, 32'h2030, 32'h0, 32'hCAFEBABE, 6};
        v[7]  = '{1'b1, 2'd1, 1'b0, 32'h2041, 32'h123456A5, 32'h0, 2};
        v[8]  = '{1'b0, 2'd2, 1'b0, 32'h2041, 32'h0, 32'h000000A5, 4};
        v[9]  = '{1'b0, 2'd2, 1'b1, 32'h2023, 32'h0, 32'h000000F2, 4};
        v[10] = '{1'b1, 2'd2, 1'b0, 32'h2050, 32'h0000817F, 32'h0, 3};
        v[11] = '{1'b0, 2'd2, 1'b1, 32'h2050, 32'h0, 32'hFFFF817F, 4};

        poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'h10); poke(16'h0103, 8'h00);
        poke(16'h2000, 8'h80); poke(16'h2010, 8'h34); poke(16'h2011, 8'h92);
        poke(16'h2020, 8'h78); poke(16'h2021, 8'h56); poke(16'h2022, 8'h34); poke(16'h2023, 8'hF2);
        poke(16'h2024, 8'h00); poke(16'h2042, 8'h00); poke(16'h3000, 8'h00); poke(16'h3003, 8'h00);
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // word fetch with per-cycle address trace
        if_addr = 32'h100; if_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4) chk($sformatf("fetch ram_a c%0d", c), ram_a, 32'h100 + c - 1);
            chk($sformatf("fetch wr/done c%0d", c), {ram_wr, if_done}, {1'b0, c == 6});
            if (c == 6) begin
                chk("fetch data", if_data, 32'h00100513);
                if_req = 1'b0;
            end
        end
        tick();

        for (int i = 0; i < 12; i++) begin
            set_mem(v[i].wr, v[i].cnf, v[i].sg, v[i].addr, v[i].wdata);
            got = 0; rd = '0;
            for (int c = 1; c <= 20; c++) begin
                tick();
                if (mem_done) begin
                    got = c; rd = mem_rdata; mem_req = 1'b0;
                    break;
                end
            end
            mem_req = 1'b0;
            chk($sformatf("vec%0d done cycle", i), got, v[i].cyc);
            if (!v[i].wr) chk($sformatf("vec%0d rdata", i), rd, v[i].rdata);
            tick();
        end

        // half store trace; neighbours stay untouched
        chk("hstore c0 wr", ram_wr, 1'b0);
        set_mem(1'b1, 2'd2, 1'b0, 32'h3001, 32'hDEADBEEF);
        tick();
        chk("hstore c1", {ram_wr, ram_a, ram_dout, mem_done}, {1'b1, 32'h3001, 8'hEF, 1'b0});
        tick();
        chk("hstore c2", {ram_wr, ram_a, ram_dout, mem_done}, {1'b1, 32'h3002, 8'hBE, 1'b0});
        tick();
        chk("hstore c3", {ram_wr, mem_done}, 2'b01);
        mem_req = 1'b0;
        tick();
        chk("hstore ram", {ram[16'h3000], ram[16'h3001], ram[16'h3002], ram[16'h3003]}, 32'h00EFBE00);

        // simultaneous: MEM word first, then IF
        set_mem(1'b0, 2'd3, 1'b0, 32'h2020, 32'h0);
        if_addr = 32'h100; if_req = 1'b1;
        gif = 0; gmem = 0;
        for (int c = 1; c <= 30 && gif == 0; c++) begin
            tick();
            if (mem_done) begin gmem = c; rd = mem_rdata; mem_req = 1'b0; end
            if (if_done) begin gif = c; if_req = 1'b0; end
        end
        mem_req = 1'b0; if_req = 1'b0;
        chk("both mem cycle", gmem, 6);
        chk("both mem data", rd, 32'hF2345678);
        chk("both if cycle", gif, 13);
        chk("both if data", if_data, 32'h00100513);
        tick();

        // flush during IF_RD with MEM pending
        if_addr = 32'h100; if_req = 1'b1;
        tick();
        set_mem(1'b0, 2'd1, 1'b1, 32'h2000, 32'h0);
        tick();
        if_flush = 1'b1; if_req = 1'b0;
        tick();
        if_flush = 1'b0;
        chk("flush c3", {ram_a, ram_wr, if_done}, '0);
        gif = 0; gmem = 0;
        for (int c = 4; c <= 20 && gmem == 0; c++) begin
            tick();
            if (if_done) gif = c;
            if (mem_done) begin gmem = c; rd = mem_rdata; mem_req = 1'b0; end
        end
        mem_req = 1'b0;
        chk("flush no if_done", gif, 0);
        chk("flush mem cycle", gmem, 6);
        chk("flush mem data", rd, 32'hFFFFFF80);
        tick();

        // flush pulse during store is ignored
        set_mem(1'b1, 2'd3, 1'b0, 32'h4000, 32'h11223344);
        tick();
        tick();
        if_flush = 1'b1;
        got = 0;
        for (int c = 3; c <= 20 && got == 0; c++) begin
            tick();
            if_flush = 1'b0;
            if (mem_done) begin got = c; mem_req = 1'b0; end
        end
        mem_req = 1'b0;
        chk("wflush cycle", got, 5);
        tick();
        chk("wflush ram", {ram[16'h4003], ram[16'h4002], ram[16'h4001], ram[16'h4000]}, 32'h11223344);

        // ignored requests: cnf=0 and if_req with if_flush
        set_mem(1'b1, 2'd0, 1'b0, 32'h5000, 32'hFFFFFFFF);
        if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h100;
        got = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (mem_done || if_done || ram_wr || ram_a != 0) got++;
        end
        chk("ignored reqs", got, 0);
        mem_req = 1'b0; if_req = 1'b0; if_flush = 1'b0;

        // address wrap
        if_addr = 32'hFFFFFFFE; if_req = 1'b1;
        tick(); chk("wrap c1", ram_a, 32'hFFFFFFFE);
        tick(); chk("wrap c2", ram_a, 32'hFFFFFFFF);
        tick(); chk("wrap c3", ram_a, 32'h00000000);
        tick(); chk("wrap c4", ram_a, 32'h00000001);
        tick(); tick();
        chk("wrap done", if_done, 1'b1);
        if_req = 1'b0;
        tick();

        // reset mid-fetch
        if_addr = 32'h100; if_req = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1; if_req = 1'b0;
        tick();
        chk_all_zero("midreset");
        rst = 1'b0;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (if_done) got++;
        end
        chk("midreset no done", got, 0);
        set_mem(1'b0, 2'd1, 1'b0, 32'h2000, 32'h0);
        got = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (mem_done) begin got = c; mem_req = 1'b0; break; end
        end
        mem_req = 1'b0;
        chk("post reset load", got, 3);
        chk("post reset data", mem_rdata, 32'h00000080);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide unified RAM port and shares it between two requesters: instruction fetch (IF, always 4-byte reads) and the MEM stage (B/H/W loads and stores, sized by the 2-bit config the EX stage produces).
- Serialises each access into little-endian byte transfers, sign/zero-extends loads, and returns a one-cycle done pulse per access.
- Sits between the IF and MEM pipeline stages and the top-level RAM pins; the EX stage's branch-interception signal cancels in-flight fetches.

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses (ram_a, if_addr, mem_addr)
- MEM_FIRST, 1, 1: MEM wins simultaneous requests; 0: IF wins

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_done or if_flush
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_flush  in  1  branch interception; cancels pending or in-flight fetch
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched instruction
- mem_req  in  1  data request, held until mem_done
- mem_wr  in  1  0 load, 1 store
- mem_cnf  in  2  0 none, 1 byte, 2 half, 3 word
- mem_signed  in  1  load sign-extension enable
- mem_addr  in  ADDR_WIDTH  data byte address
- mem_wdata  in  32  store data (low bytes used)
- mem_done  out  1  one-cycle pulse; access complete, mem_rdata valid for loads
- mem_rdata  out  32  extended load result
- ram_a  out  ADDR_WIDTH  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; returns data for the ram_a of the previous cycle

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE. All outputs are registered.
- Reset, and any cycle with rst=1 including mid-access: state=IDLE, byte counter=0. All outputs are 0: ram_a, ram_wr, ram_dout, if_done, if_data, mem_done, mem_rdata. No done pulse is produced for the aborted access.
- Request validity: mem_req with mem_cnf=0 is ignored.
- Request validity: if_req with if_flush=1 in the same cycle is ignored.
- IDLE arbitration: valid requests are sampled each IDLE cycle.
  - Both valid: MEM_FIRST selects the winner; the loser stays pending. There is no round-robin.
  - Accepting latches addr, size n (IF: 4; MEM: 1/2/4), wr, signed and wdata.
- Cycle numbering: the acceptance cycle is cycle 0.
- Read (IF_RD / MEM_RD):
  - ram_a = addr+k, ram_wr=0 in cycle k+1, for k = 0..n-1.
  - Byte k is captured from ram_din at the end of cycle k+2 into bits [8k+7:8k].
  - The done pulse is in cycle n+2: word read done in cycle 6, byte read done in cycle 3.
- Write (MEM_WR):
  - ram_a = addr+k, ram_wr=1, ram_dout = wdata[8k+7:8k] in cycle k+1.
  - mem_done pulses in cycle n+1. ram_wr=0 in every other cycle.
- Load extension:
  - cnf=1: bit 7 replicated if signed, else zero-filled.
  - cnf=2: bit 15 replicated if signed, else zero-filled.
  - cnf=3: passed unchanged.
- DONE state:
  - Lasts exactly one cycle; the done output is high during it.
  - Requests are not sampled in DONE. The requester may still hold req that cycle and must drop it or present a new request by the next cycle.
  - DONE -> IDLE.
- if_data / mem_rdata hold their last value until the next completion.
- Flush:
  - if_flush=1 during IF_RD aborts the fetch. Next cycle: state=IDLE, ram_a=0, no if_done.
  - Requests are sampled again in the cycle after the abort.
  - if_flush has no effect on MEM_RD / MEM_WR; stores always complete all bytes.
- Address arithmetic: addr+k wraps modulo 2^ADDR_WIDTH.
- mem_addr alignment: not checked; any byte address is serialised as-is.
- Throughput: back-to-back word fetches take 7 cycles each (accept, 4 address cycles, 1 capture, DONE).

Test Plan:
- Reset mid-fetch: assert rst in cycle 3 of an IF_RD -> next cycle all outputs 0, state IDLE, no if_done afterwards.
- IF word read: RAM[0x100..0x103] = 13,05,10,00, if_req with if_addr=0x100 -> ram_a runs 0x100..0x103 in cycles 1-4, if_done in cycle 6, if_data=0x00100513.
- Signed byte load: RAM[0x2000]=0x80, mem_cnf=1, mem_signed=1 -> mem_done in cycle 3, mem_rdata=0xFFFFFF80. Same with mem_signed=0 -> 0x00000080.
- Half store: mem_wr=1, mem_cnf=2, addr=0x3001, wdata=0xDEADBEEF -> ram_wr=1 with (0x3001,0xEF) in cycle 1 and (0x3002,0xBE) in cycle 2. mem_done in cycle 3; ram_wr=0 in cycles 0 and 3.
- Simultaneous requests with MEM_FIRST=1: both asserted in the same IDLE cycle -> MEM word load completes first (done in cycle 6). DONE in cycle 6, IDLE in cycle 7, IF accepted in cycle 7, if_done in cycle 13.
- Flush: if_flush pulsed in cycle 2 of IF_RD -> no if_done, ram_wr stays 0, state IDLE in cycle 3. A pending mem_req is accepted in cycle 3. The same flush pulse during MEM_WR leaves all 4 store bytes written.
